// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_pkg;

    // Sequencer FSM states; each state names what the ALU-side outputs carry.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_A = 2'd1,
        ISSUE_B = 2'd2,
        HOLD    = 2'd3
    } seq_state_t;

    // INP_VALID encodings.
    localparam logic [1:0] IV_NONE = 2'b00;
    localparam logic [1:0] IV_A    = 2'b01;
    localparam logic [1:0] IV_B    = 2'b10;
    localparam logic [1:0] IV_BOTH = 2'b11;

    // Arithmetic-mode command codes (MODE=1).
    typedef enum logic [3:0] {
        CMD_ADD     = 4'd0,
        CMD_SUB     = 4'd1,
        CMD_ADD_CIN = 4'd2,
        CMD_SUB_CIN = 4'd3,
        CMD_INC_A   = 4'd4,
        CMD_DEC_A   = 4'd5,
        CMD_INC_B   = 4'd6,
        CMD_DEC_B   = 4'd7,
        CMD_CMP     = 4'd8,
        CMD_MUL_INC = 4'd9,
        CMD_MUL_SHL = 4'd10
    } arith_cmd_t;

    // Logical-mode command codes (MODE=0).
    typedef enum logic [3:0] {
        CMD_AND  = 4'd0,
        CMD_NAND = 4'd1,
        CMD_OR   = 4'd2,
        CMD_NOR  = 4'd3,
        CMD_XOR  = 4'd4,
        CMD_XNOR = 4'd5,
        CMD_NOTA = 4'd6,
        CMD_NOTB = 4'd7
    } logic_cmd_t;

    // Multiply commands need idle cycles after their last beat.
    function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHL));
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and ALU-side signal bundle for the ALU operation sequencer.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_MODE;
    logic [3:0]       REQ_CMD;
    logic [WIDTH-1:0] REQ_OPA;
    logic [WIDTH-1:0] REQ_OPB;
    logic             REQ_CIN;
    logic             REQ_SPLIT;
    logic [1:0]       INP_VALID;
    logic             MODE;
    logic [3:0]       CMD;
    logic             CE;
    logic [WIDTH-1:0] OPA;
    logic [WIDTH-1:0] OPB;
    logic             CIN;
    logic [15:0]      ISSUE_CNT;

    modport master (
        output EN, REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN, REQ_SPLIT,
        input  REQ_READY, INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, ISSUE_CNT
    );

    modport slave (
        input  EN, REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN, REQ_SPLIT,
        output REQ_READY, INP_VALID, MODE, CMD, CE, OPA, OPB, CIN, ISSUE_CNT
    );
endinterface

// File: rtl/alu_req_fifo.sv
// Request FIFO: DEPTH entries of WIDTH bits, full blocks pushes even when popping.
module alu_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences buffered ALU requests into registered operand beats for the ALU.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int MUL_GAP = 2
) (
    input logic               CLK,
    input logic               RST_N,
    alu_op_sequencer_if.slave bus
);
    localparam int              REQ_W    = 2*WIDTH + 7;
    localparam int              GAP_W    = (MUL_GAP > 1) ? $clog2(MUL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MUL_GAP > 0) ? MUL_GAP - 1 : 0);
    localparam bit              HAS_GAP  = (MUL_GAP > 0);

    logic [REQ_W-1:0] wdata;
    logic [REQ_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             ready_ok;

    seq_state_t       state_q, state_d;
    logic [GAP_W-1:0] hold_q, hold_d;
    logic             tail_q, tail_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [1:0]       iv_q, iv_d;
    logic             mode_q, mode_d;
    logic [3:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             cin_q, cin_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             ce_q;
    logic             slot;

    logic             head_split;
    logic             head_cin;
    logic             head_mode;
    logic [3:0]       head_cmd;
    logic [WIDTH-1:0] head_opa;
    logic [WIDTH-1:0] head_opb;

    assign wdata = {bus.REQ_SPLIT, bus.REQ_CIN, bus.REQ_MODE, bus.REQ_CMD, bus.REQ_OPA, bus.REQ_OPB};
    assign {head_split, head_cin, head_mode, head_cmd, head_opa, head_opb} = head;

    assign bus.REQ_READY = ready_ok && !fifo_full;
    assign push          = bus.REQ_VALID && bus.REQ_READY;

    alu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Keeps REQ_READY low until the first clock edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) ready_ok <= 1'b0;
        else        ready_ok <= 1'b1;
    end

    // Next-state and next-output decision; tail_q marks a just-issued final multiply beat.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tail_d  = tail_q;
        pend_d  = pend_q;
        iv_d    = IV_NONE;
        mode_d  = mode_q;
        cmd_d   = cmd_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        slot    = 1'b0;

        if (bus.EN) begin
            case (state_q)
                IDLE, ISSUE_B: begin
                    if (tail_q) begin
                        state_d = HOLD;
                        hold_d  = GAP_LOAD;
                        tail_d  = 1'b0;
                    end else begin
                        slot = 1'b1;
                    end
                end
                ISSUE_A: begin
                    iv_d    = IV_B;
                    opb_d   = pend_q;
                    cnt_d   = cnt_q + 16'd1;
                    tail_d  = HAS_GAP && is_mul(mode_q, cmd_q);
                    state_d = ISSUE_B;
                end
                HOLD: begin
                    if (hold_q == '0) slot = 1'b1;
                    else              hold_d = hold_q - 1'b1;
                end
                default: ;
            endcase

            if (slot) begin
                state_d = IDLE;
                tail_d  = 1'b0;
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    mode_d = head_mode;
                    cmd_d  = head_cmd;
                    opa_d  = head_opa;
                    cin_d  = head_cin;
                    if (head_split) begin
                        iv_d    = IV_A;
                        pend_d  = head_opb;
                        state_d = ISSUE_A;
                    end else begin
                        iv_d   = IV_BOTH;
                        opb_d  = head_opb;
                        cnt_d  = cnt_q + 16'd1;
                        tail_d = HAS_GAP && is_mul(head_mode, head_cmd);
                    end
                end
            end
        end
    end

    // State, hold counter and registered ALU-side outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            hold_q  <= '0;
            tail_q  <= 1'b0;
            pend_q  <= '0;
            iv_q    <= IV_NONE;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tail_q  <= tail_d;
            pend_q  <= pend_d;
            iv_q    <= iv_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            ce_q    <= bus.EN;
        end
    end

    assign bus.INP_VALID = iv_q;
    assign bus.MODE      = mode_q;
    assign bus.CMD       = cmd_q;
    assign bus.OPA       = opa_q;
    assign bus.OPB       = opb_q;
    assign bus.CIN       = cin_q;
    assign bus.ISSUE_CNT = cnt_q;
    assign bus.CE        = ce_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a beat-level model.
module tb_alu_op_sequencer;
    localparam int W = 8;
    localparam int D = 4;
    localparam int G = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;

    alu_op_sequencer_if #(.WIDTH(W)) bus ();

    alu_op_sequencer #(
        .WIDTH   (W),
        .DEPTH   (D),
        .MUL_GAP (G)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         mode;
        logic [3:0] cmd;
        logic [W-1:0] opa;
        logic [W-1:0] opb;
        bit         cin;
        bit         split;
    } req_t;

    int n_err;
    int n_checks;

    // Stimulus for the current cycle.
    bit           d_en, d_valid, d_mode, d_cin, d_split;
    logic [3:0]   d_cmd;
    logic [W-1:0] d_opa, d_opb;

    // Reference model: accepted requests, pending second beat, blank decisions owed.
    req_t         q[$];
    bit           pend_b;
    logic [W-1:0] pend_opb;
    bit           pend_mul;
    int           blank_left;
    bit           rdy_ok;
    logic [1:0]   e_iv;
    bit           e_mode, e_cin, e_ce;
    logic [3:0]   e_cmd;
    logic [W-1:0] e_opa, e_opb;
    logic [15:0]  e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit tb_mul(input bit m, input logic [3:0] c);
        return m && (c == 4'd9 || c == 4'd10);
    endfunction

    task automatic model_clear();
        q.delete();
        pend_b = 0; pend_opb = '0; pend_mul = 0; blank_left = 0; rdy_ok = 0;
        e_iv = 2'b00; e_mode = 0; e_cin = 0; e_ce = 0; e_cmd = '0;
        e_opa = '0; e_opb = '0; e_cnt = '0;
    endtask

    // One enabled cycle yields at most one beat; a final multiply beat owes G blank decisions.
    task automatic model_step();
        req_t r;
        bit   rdy;
        rdy  = rdy_ok && (q.size() < D);
        e_ce = d_en;
        e_iv = 2'b00;
        if (d_en) begin
            if (pend_b) begin
                e_iv   = 2'b10;
                e_opb  = pend_opb;
                e_cnt  = e_cnt + 16'd1;
                pend_b = 0;
                if (pend_mul) blank_left = G;
            end else if (blank_left > 0) begin
                blank_left--;
            end else if (q.size() > 0) begin
                r      = q.pop_front();
                e_mode = r.mode; e_cmd = r.cmd; e_opa = r.opa; e_cin = r.cin;
                if (r.split) begin
                    e_iv     = 2'b01;
                    pend_b   = 1;
                    pend_opb = r.opb;
                    pend_mul = tb_mul(r.mode, r.cmd);
                end else begin
                    e_iv  = 2'b11;
                    e_opb = r.opb;
                    e_cnt = e_cnt + 16'd1;
                    if (tb_mul(r.mode, r.cmd)) blank_left = G;
                end
            end
        end
        if (d_valid && rdy) begin
            r.mode = d_mode; r.cmd = d_cmd; r.opa = d_opa; r.opb = d_opb;
            r.cin = d_cin; r.split = d_split;
            q.push_back(r);
        end
        rdy_ok = 1;
    endtask

    task automatic compare_outputs();
        bit rdy;
        rdy = rdy_ok && (q.size() < D);
        check("inp_valid", 32'(bus.INP_VALID), 32'(e_iv));
        check("req_ready", 32'(bus.REQ_READY), 32'(rdy));
        check("mode",      32'(bus.MODE),      32'(e_mode));
        check("cmd",       32'(bus.CMD),       32'(e_cmd));
        check("opa",       32'(bus.OPA),       32'(e_opa));
        check("opb",       32'(bus.OPB),       32'(e_opb));
        check("cin",       32'(bus.CIN),       32'(e_cin));
        check("issue_cnt", 32'(bus.ISSUE_CNT), 32'(e_cnt));
        check("ce",        32'(bus.CE),        32'(e_ce));
    endtask

    task automatic apply_drive();
        bus.EN = d_en; bus.REQ_VALID = d_valid; bus.REQ_MODE = d_mode;
        bus.REQ_CMD = d_cmd; bus.REQ_OPA = d_opa; bus.REQ_OPB = d_opb;
        bus.REQ_CIN = d_cin; bus.REQ_SPLIT = d_split;
    endtask

    task automatic randomize_drive();
        d_en    = ($urandom_range(0, 9) != 0);
        d_valid = ($urandom_range(0, 2) != 0);
        d_mode  = 1'($urandom_range(0, 1));
        d_cin   = 1'($urandom_range(0, 1));
        d_split = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) d_cmd = ($urandom_range(0, 1) != 0) ? 4'd9 : 4'd10;
        else                           d_cmd = 4'($urandom_range(0, 15));
        d_opa = W'($urandom);
        d_opb = W'($urandom);
    endtask

    task automatic cycle(input bit rnd);
        if (rnd) randomize_drive();
        @(posedge CLK);
        #1;
        compare_outputs();
        apply_drive();
        model_step();
    endtask

    task automatic set_req(input bit mode, input logic [3:0] cmd, input logic [W-1:0] opa,
                           input logic [W-1:0] opb, input bit cin, input bit split);
        d_en = 1; d_valid = 1; d_mode = mode; d_cmd = cmd;
        d_opa = opa; d_opb = opb; d_cin = cin; d_split = split;
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases between edges.
    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        model_clear();
        compare_outputs();
        repeat (2) @(posedge CLK);
        #1;
        compare_outputs();
        RST_N = 1'b1;
        d_en = 1; d_valid = 0;
        apply_drive();
        model_step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found, saw_b, got_add;
        int zeros;
        n_err = 0; n_checks = 0;
        d_en = 0; d_valid = 0; d_mode = 0; d_cin = 0; d_split = 0;
        d_cmd = '0; d_opa = '0; d_opb = '0;
        model_clear();
        apply_drive();
        #2;
        do_reset();

        // Single unsplit request: beat two cycles after entry.
        set_req(1, 4'd0, 8'h0F, 8'h01, 0, 0);
        cycle(0);
        d_valid = 0;
        cycle(0);
        check("single_gap_iv", 32'(bus.INP_VALID), 32'h0);
        cycle(0);
        check("single_iv",  32'(bus.INP_VALID), 32'h3);
        check("single_opa", 32'(bus.OPA), 32'h0F);
        check("single_opb", 32'(bus.OPB), 32'h01);
        check("single_cnt", 32'(bus.ISSUE_CNT), 32'h1);

        // Split request: A beat then B beat on consecutive cycles, counted once.
        do_reset();
        set_req(0, 4'd2, 8'hAA, 8'h55, 1, 1);
        cycle(0);
        d_valid = 0;
        cycle(0);
        cycle(0);
        check("split_a_iv",  32'(bus.INP_VALID), 32'h1);
        check("split_a_opa", 32'(bus.OPA), 32'hAA);
        check("split_a_cnt", 32'(bus.ISSUE_CNT), 32'h0);
        cycle(0);
        check("split_b_iv",  32'(bus.INP_VALID), 32'h2);
        check("split_b_opb", 32'(bus.OPB), 32'h55);
        check("split_b_cnt", 32'(bus.ISSUE_CNT), 32'h1);
        cycle(0);
        check("split_end_iv", 32'(bus.INP_VALID), 32'h0);

        // Multiply followed by add: exactly G blank cycles between them.
        do_reset();
        set_req(1, 4'd9, 8'h03, 8'h04, 0, 0);
        cycle(0);
        set_req(1, 4'd0, 8'h11, 8'h22, 0, 0);
        cycle(0);
        d_valid = 0;
        found = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(0);
            if (bus.INP_VALID == 2'b11 && bus.CMD == 4'd9) begin
                found = 1;
                break;
            end
        end
        check("mul_seen", 32'(found), 32'h1);
        zeros = 0; got_add = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            cycle(0);
            if (bus.INP_VALID == 2'b00) zeros++;
            else begin
                got_add = (bus.INP_VALID == 2'b11) && (bus.CMD == 4'd0);
                break;
            end
        end
        check("mul_gap", 32'(zeros), 32'(G));
        check("add_after_mul", 32'(got_add), 32'h1);

        // Fill while disabled, then drain back-to-back.
        do_reset();
        for (int unsigned i = 0; i < 5; i++) begin
            set_req(0, 4'(i), 8'(i + 1), 8'(i + 8'h10), 0, 0);
            d_en = 0;
            cycle(0);
            if (i == 4) check("full_ready", 32'(bus.REQ_READY), 32'h0);
        end
        d_valid = 0; d_en = 1;
        cycle(0);
        check("full_still_full", 32'(bus.REQ_READY), 32'h0);
        for (int unsigned k = 0; k < 4; k++) begin
            cycle(0);
            check("b2b_iv", 32'(bus.INP_VALID), 32'h3);
            check("b2b_opa", 32'(bus.OPA), 32'(k + 1));
            if (k == 0) check("ready_back", 32'(bus.REQ_READY), 32'h1);
        end
        cycle(0);
        check("b2b_done_iv", 32'(bus.INP_VALID), 32'h0);
        check("b2b_cnt", 32'(bus.ISSUE_CNT), 32'h4);

        // Reset during the A beat drops the pending B beat.
        do_reset();
        set_req(1, 4'd0, 8'hAA, 8'h55, 0, 1);
        cycle(0);
        d_valid = 0;
        found = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            cycle(0);
            if (bus.INP_VALID == 2'b01) begin
                found = 1;
                break;
            end
        end
        check("rst_a_seen", 32'(found), 32'h1);
        do_reset();
        saw_b = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            cycle(0);
            if (bus.INP_VALID == 2'b10) saw_b = 1;
        end
        check("no_b_after_rst", 32'(saw_b), 32'h0);

        // Randomized traffic with occasional resets.
        for (int unsigned i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else                             cycle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width (matches ALU OPA/OPB).
REQ-002 SHALL have parameter DEPTH, default 4, meaning request FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter MUL_GAP, default 2, meaning idle cycles inserted after a multiply issue.
REQ-004 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EN  input  1  global enable; low freezes issue and state.
REQ-007 SHALL have port REQ_VALID  input  1  request present.
REQ-008 SHALL have port REQ_READY  output  1  FIFO not full; request accepted when VALID&&READY.
REQ-009 SHALL have port REQ_MODE  input  1  1=arithmetic, 0=logical.
REQ-010 SHALL have port REQ_CMD  input  4  ALU command code.
REQ-011 SHALL have port REQ_OPA  input  WIDTH  operand A.
REQ-012 SHALL have port REQ_OPB  input  WIDTH  operand B.
REQ-013 SHALL have port REQ_CIN  input  1  carry-in.
REQ-014 SHALL have port REQ_SPLIT  input  1  issue A and B in separate beats.
REQ-015 SHALL have port INP_VALID  output  2  to ALU: 01=A only, 10=B only, 11=both, 00=none.
REQ-016 SHALL have port MODE  output  1  to ALU.
REQ-017 SHALL have port CMD  output  4  to ALU.
REQ-018 SHALL have port CE  output  1  to ALU clock enable; equals EN registered.
REQ-019 SHALL have port OPA  output  WIDTH  to ALU.
REQ-020 SHALL have port OPB  output  WIDTH  to ALU.
REQ-021 SHALL have port CIN  output  1  to ALU.
REQ-022 SHALL have port ISSUE_CNT  output  16  completed issues, wraps 0xFFFF->0x0000.

Function
REQ-023 SHALL buffer accepted requests in a DEPTH-entry FIFO; REQ_READY=0 exactly when DEPTH entries held, including cycles where a pop is simultaneous.
REQ-024 SHALL accept a push and pop in the same cycle when not full, occupancy unchanged.
REQ-025 SHALL use FSM states IDLE, ISSUE_A, ISSUE_B, HOLD; all ALU-side outputs registered.
REQ-026 IDLE: if EN and FIFO non-empty, pop head; SPLIT=0 -> drive INP_VALID=11 next cycle (ISSUE_BOTH beat, stays in IDLE path); SPLIT=1 -> go ISSUE_A.
REQ-027 ISSUE_A: drive INP_VALID=01 with OPA, CMD, MODE, CIN for one cycle, then ISSUE_B.
REQ-028 ISSUE_B: drive INP_VALID=10 with OPB, same CMD/MODE/CIN held, one cycle later than ISSUE_A.
REQ-029 Issue latency: request entering empty FIFO in cycle N appears on INP_VALID in cycle N+2 (N+1 FIFO write, N+2 registered output).
REQ-030 Multiply = MODE=1 and CMD 9 or 10; after its final beat SHALL enter HOLD for MUL_GAP cycles with INP_VALID=00, then IDLE.
REQ-031 Non-multiply issues SHALL be back-to-back: one issue beat per cycle when FIFO non-empty.
REQ-032 INP_VALID SHALL be 00 in every cycle no beat is issued; OPA/OPB/CMD hold last values.
REQ-033 EN=0 SHALL freeze FSM, HOLD counter and FIFO pop; INP_VALID forced 00; pushes still accepted.
REQ-034 ISSUE_CNT SHALL increment once per request, on its last beat (11 or 10).

Reset
REQ-035 RST_N low SHALL asynchronously clear FIFO, state=IDLE, INP_VALID=00, MODE=0, CMD=0, CE=0, OPA=0, OPB=0, CIN=0, ISSUE_CNT=0, REQ_READY=0.
REQ-036 Reset mid-split or mid-HOLD SHALL drop the in-flight request; REQ_READY=1 first cycle after deassertion.

Structure
REQ-037 Shared package alu_pkg SHALL hold state enum, CMD codes, and multiply-command constants.
REQ-038 FIFO SHALL be sub-module alu_req_fifo (parameterised WIDTH, DEPTH).

Verification
REQ-039 Single request MODE=1 CMD=0 OPA=8'h0F OPB=8'h01 SPLIT=0 -> INP_VALID=11 with those values 2 cycles later, ISSUE_CNT=1.
REQ-040 SPLIT=1 OPA=8'hAA OPB=8'h55 -> INP_VALID=01/OPA=AA then 10/OPB=55 consecutive cycles, count +1 once.
REQ-041 Multiply MODE=1 CMD=9 followed by add -> exactly 2 INP_VALID=00 cycles between them.
REQ-042 Push 5 requests with EN=0, DEPTH=4 -> REQ_READY=0 after 4th; EN=1 -> 4 back-to-back issues, ready reasserts.
REQ-043 RST_N low during ISSUE_A -> all outputs zero immediately, second beat never issued.
